// File: rtl/udp_pkt_gen_pkg.sv
// udp_pkt_gen_pkg: shared types and constants for the UDP traffic generator.
package udp_pkt_gen_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PAYLOAD, ST_GAP} udp_pkt_gen_state_t;
    typedef enum logic {MODE_CONST, MODE_INCR} udp_pkt_gen_mode_t;
    localparam int UDP_HDR_BYTES = 8;
    localparam int SEQ_BYTES = 4;
endpackage

// File: rtl/udp_pkt_gen_payload.sv
// udp_pkt_gen_payload: selects the payload byte for a given index.
// Bytes 0..3 carry the big-endian sequence number; later bytes are fill or (index-4) mod 256.
module udp_pkt_gen_payload
    import udp_pkt_gen_pkg::*;
#(
    parameter int IDX_W = 11
) (
    input  logic [IDX_W-1:0]  idx,
    input  logic [31:0]       seq,
    input  udp_pkt_gen_mode_t mode,
    input  logic [7:0]        fill,
    output logic [7:0]        data
);
    logic [7:0] seq_byte;
    logic [7:0] ramp;

    always_comb begin
        seq_byte = idx[1:0] == 2'd0 ? seq[31:24] :
                   idx[1:0] == 2'd1 ? seq[23:16] :
                   idx[1:0] == 2'd2 ? seq[15:8]  : seq[7:0];
        ramp     = 8'(idx) - 8'(SEQ_BYTES);
        data     = idx < IDX_W'(SEQ_BYTES) ? seq_byte : mode == MODE_INCR ? ramp : fill;
    end
endmodule

// File: rtl/udp_pkt_gen.sv
// udp_pkt_gen: UDP traffic generator driving the stack's TX header/payload streams.
// Each payload begins with a 32-bit sequence number; RX traffic is accepted and dropped.
module udp_pkt_gen
    import udp_pkt_gen_pkg::*;
#(
    parameter int          PAYLOAD_LEN_MAX = 1472,
    parameter logic [31:0] SOURCE_IP       = {8'd192, 8'd168, 8'd1, 8'd128},
    parameter logic [31:0] DEST_IP         = {8'd192, 8'd168, 8'd1, 8'd2},
    parameter logic [15:0] SOURCE_PORT     = 16'd1234,
    parameter logic [15:0] DEST_PORT       = 16'd5678,
    parameter logic [7:0]  TTL             = 8'd64,
    parameter logic [7:0]  FILL_BYTE       = 8'h45,
    localparam int         LEN_W           = $clog2(PAYLOAD_LEN_MAX + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic             tx_hdr_valid,
    input  logic             tx_hdr_ready,
    output logic [31:0]      tx_hdr_ip_src,
    output logic [31:0]      tx_hdr_ip_dst,
    output logic [15:0]      tx_hdr_src_port,
    output logic [15:0]      tx_hdr_dst_port,
    output logic [15:0]      tx_hdr_length,
    output logic [15:0]      tx_hdr_checksum,
    output logic [7:0]       tx_hdr_ttl,
    output logic [5:0]       tx_hdr_ip_dscp,
    output logic [1:0]       tx_hdr_ip_ecn,
    output logic [7:0]       tx_tdata,
    output logic             tx_tvalid,
    input  logic             tx_tready,
    output logic             tx_tlast,
    output logic             tx_tuser,
    input  logic             rx_hdr_valid,
    output logic             rx_hdr_ready,
    input  logic [7:0]       rx_tdata,
    input  logic             rx_tvalid,
    output logic             rx_tready,
    input  logic             rx_tlast,
    input  logic             enable,
    input  logic             mode,
    input  logic [LEN_W-1:0] payload_len,
    input  logic [15:0]      gap_cycles,
    output logic [31:0]      pkt_count,
    output logic             busy
);
    udp_pkt_gen_state_t state, state_nxt;
    udp_pkt_gen_mode_t  mode_r;
    logic [LEN_W-1:0]   len_eff, len_r, idx, idx_nxt;
    logic [31:0]        seq_r;
    logic [15:0]        gap_cnt;
    logic [7:0]         byte_nxt;
    logic               start, hdr_hs, byte_hs, last_hs;
    logic               rx_unused;

    assign len_eff  = payload_len == '0 ? LEN_W'(1) :
                      payload_len > LEN_W'(PAYLOAD_LEN_MAX) ? LEN_W'(PAYLOAD_LEN_MAX) : payload_len;
    assign start    = state == ST_IDLE && enable;
    assign hdr_hs   = tx_hdr_valid && tx_hdr_ready;
    assign byte_hs  = tx_tvalid && tx_tready;
    assign last_hs  = byte_hs && tx_tlast;
    // The selector looks one byte ahead so tdata can be registered.
    assign idx_nxt  = state == ST_HDR ? '0 : idx + 1'b1;

    assign tx_hdr_ip_src   = SOURCE_IP;
    assign tx_hdr_ip_dst   = DEST_IP;
    assign tx_hdr_src_port = SOURCE_PORT;
    assign tx_hdr_dst_port = DEST_PORT;
    assign tx_hdr_checksum = '0;
    assign tx_hdr_ttl      = TTL;
    assign tx_hdr_ip_dscp  = '0;
    assign tx_hdr_ip_ecn   = '0;
    assign tx_tuser        = 1'b0;
    assign rx_unused       = ^{rx_hdr_valid, rx_tdata, rx_tvalid, rx_tlast};

    udp_pkt_gen_payload #(.IDX_W(LEN_W)) u_payload (
        .idx  (idx_nxt),
        .seq  (seq_r),
        .mode (mode_r),
        .fill (FILL_BYTE),
        .data (byte_nxt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    state_nxt = enable ? ST_HDR : ST_IDLE;
            ST_HDR:     state_nxt = hdr_hs ? ST_PAYLOAD : ST_HDR;
            ST_PAYLOAD: state_nxt = !last_hs ? ST_PAYLOAD : gap_cycles != '0 ? ST_GAP : ST_IDLE;
            ST_GAP:     state_nxt = gap_cnt == 16'd1 ? ST_IDLE : ST_GAP;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy         = state != ST_IDLE;
        rx_hdr_ready = 1'b1;
        rx_tready    = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_r        <= MODE_CONST;
            len_r         <= '0;
            seq_r         <= '0;
            idx           <= '0;
            gap_cnt       <= '0;
            pkt_count     <= '0;
            tx_hdr_valid  <= 1'b0;
            tx_hdr_length <= '0;
            tx_tdata      <= '0;
            tx_tvalid     <= 1'b0;
            tx_tlast      <= 1'b0;
        end else begin
            if (start) begin
                mode_r        <= udp_pkt_gen_mode_t'(mode);
                len_r         <= len_eff;
                seq_r         <= pkt_count;
                tx_hdr_length <= 16'(len_eff) + 16'(UDP_HDR_BYTES);
                tx_hdr_valid  <= 1'b1;
            end
            if (hdr_hs)
                tx_hdr_valid <= 1'b0;
            if (hdr_hs || (byte_hs && !tx_tlast)) begin
                idx       <= idx_nxt;
                tx_tdata  <= byte_nxt;
                tx_tvalid <= 1'b1;
                tx_tlast  <= idx_nxt == len_r - 1'b1;
            end else if (last_hs) begin
                tx_tvalid <= 1'b0;
                tx_tlast  <= 1'b0;
                pkt_count <= pkt_count + 1'b1;
                gap_cnt   <= gap_cycles;
            end else if (state == ST_GAP) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_udp_pkt_gen.sv
// tb_udp_pkt_gen: randomized self-checking bench for udp_pkt_gen.
// Expected bytes, lengths and timing come from a plain arithmetic packet model.
module tb_udp_pkt_gen;
    localparam int MAXL  = 1472;
    localparam int LEN_W = 11;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic             tx_hdr_valid, tx_hdr_ready;
    logic [31:0]      tx_hdr_ip_src, tx_hdr_ip_dst;
    logic [15:0]      tx_hdr_src_port, tx_hdr_dst_port, tx_hdr_length, tx_hdr_checksum;
    logic [7:0]       tx_hdr_ttl;
    logic [5:0]       tx_hdr_ip_dscp;
    logic [1:0]       tx_hdr_ip_ecn;
    logic [7:0]       tx_tdata;
    logic             tx_tvalid, tx_tready, tx_tlast, tx_tuser;
    logic             rx_hdr_valid, rx_hdr_ready, rx_tvalid, rx_tready, rx_tlast;
    logic [7:0]       rx_tdata;
    logic             enable, mode, busy;
    logic [LEN_W-1:0] payload_len;
    logic [15:0]      gap_cycles;
    logic [31:0]      pkt_count;

    udp_pkt_gen dut (
        .clk(clk), .reset_n(reset_n),
        .tx_hdr_valid(tx_hdr_valid), .tx_hdr_ready(tx_hdr_ready),
        .tx_hdr_ip_src(tx_hdr_ip_src), .tx_hdr_ip_dst(tx_hdr_ip_dst),
        .tx_hdr_src_port(tx_hdr_src_port), .tx_hdr_dst_port(tx_hdr_dst_port),
        .tx_hdr_length(tx_hdr_length), .tx_hdr_checksum(tx_hdr_checksum),
        .tx_hdr_ttl(tx_hdr_ttl), .tx_hdr_ip_dscp(tx_hdr_ip_dscp), .tx_hdr_ip_ecn(tx_hdr_ip_ecn),
        .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
        .tx_tlast(tx_tlast), .tx_tuser(tx_tuser),
        .rx_hdr_valid(rx_hdr_valid), .rx_hdr_ready(rx_hdr_ready),
        .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tlast(rx_tlast),
        .enable(enable), .mode(mode), .payload_len(payload_len), .gap_cycles(gap_cycles),
        .pkt_count(pkt_count), .busy(busy)
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_seq = 0;
    logic [7:0]  got[$];
    logic [15:0] got_len;
    int          got_last, got_err;

    function automatic int model_len(int pl);
        return pl == 0 ? 1 : pl > MAXL ? MAXL : pl;
    endfunction

    function automatic logic [7:0] model_byte(int i, logic [31:0] seq, bit m);
        if (i < 4) return 8'(seq >> (8 * (3 - i)));
        return m ? 8'((i - 4) % 256) : 8'h45;
    endfunction

    // Collects one packet; got_err counts protocol problems (timeouts, unstable data while stalled).
    task automatic capture(input bit bp, input int drop_at);
        int n;
        bit r, pv, pl, done;
        logic [7:0] pd;
        logic [15:0] plen;
        got.delete();
        got_last = -1;
        got_err = 0;
        n = 0;
        while (tx_hdr_valid !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        if (tx_hdr_valid !== 1'b1) begin got_err++; return; end
        got_len = tx_hdr_length;
        do begin
            r = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            tx_hdr_ready = r;
            plen = tx_hdr_length;
            @(negedge clk);
            if (!r && (tx_hdr_valid !== 1'b1 || tx_hdr_length !== plen)) got_err++;
        end while (!r);
        tx_hdr_ready = 1'b0;
        if (tx_tvalid !== 1'b1) got_err++;
        done = 0;
        n = 0;
        while (!done && n < 5000) begin
            r = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            tx_tready = r;
            pv = tx_tvalid;
            pd = tx_tdata;
            pl = tx_tlast;
            if (!pv) got_err++;
            if (pv && r) begin
                got.push_back(pd);
                if (pl) begin got_last = got.size() - 1; done = 1; end
                if (got.size() == drop_at) enable = 1'b0;
            end
            @(negedge clk);
            n++;
            if (pv && !r && (tx_tvalid !== 1'b1 || tx_tdata !== pd || tx_tlast !== pl)) got_err++;
        end
        if (!done) got_err++;
        tx_tready = 1'b0;
    endtask

    task automatic do_reset();
        enable = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        exp_seq = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        @(negedge clk);
        vectors++; if (tx_hdr_valid !== 1'b0) begin miscompares++; $display("FAIL rst_hdr_valid got %0b exp 0", tx_hdr_valid); end
        vectors++; if (tx_tvalid !== 1'b0) begin miscompares++; $display("FAIL rst_tvalid got %0b exp 0", tx_tvalid); end
        vectors++; if (tx_tlast !== 1'b0) begin miscompares++; $display("FAIL rst_tlast got %0b exp 0", tx_tlast); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %0b exp 0", busy); end
        vectors++; if (pkt_count !== 32'd0) begin miscompares++; $display("FAIL rst_pkt_count got %0d exp 0", pkt_count); end
        vectors++; if (tx_tdata !== 8'h00) begin miscompares++; $display("FAIL rst_tdata got %02h exp 00", tx_tdata); end
        vectors++; if (rx_hdr_ready !== 1'b1 || rx_tready !== 1'b1) begin miscompares++; $display("FAIL rx_ready got %0b%0b exp 11", rx_hdr_ready, rx_tready); end
        vectors++; if (tx_hdr_ttl !== 8'd64 || tx_hdr_src_port !== 16'd1234 || tx_hdr_dst_port !== 16'd5678) begin
            miscompares++; $display("FAIL hdr_const got ttl %0d sp %0d dp %0d exp 64 1234 5678", tx_hdr_ttl, tx_hdr_src_port, tx_hdr_dst_port);
        end
        do_reset();
    endtask

    task automatic test_len1();
        int n;
        logic [31:0] s;
        mode = 1'b0; payload_len = 11'd1; gap_cycles = 16'd0; enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            capture(0, -1);
            if (k == 3) enable = 1'b0;
            s = exp_seq; exp_seq++;
            vectors++; if (got_err != 0) begin miscompares++; $display("FAIL len1_proto got %0d exp 0", got_err); end
            vectors++; if (got_len !== 16'd9) begin miscompares++; $display("FAIL len1_length got %0d exp 9", got_len); end
            vectors++; if (got.size() != 1 || got_last != 0) begin miscompares++; $display("FAIL len1_count got %0d/%0d exp 1/0", got.size(), got_last); end
            for (int i = 0; i < got.size(); i++) begin
                vectors++; if (got[i] !== model_byte(i, s, 0)) begin miscompares++; $display("FAIL len1_byte got %02h exp %02h", got[i], model_byte(i, s, 0)); end
            end
            vectors++; if (pkt_count !== exp_seq) begin miscompares++; $display("FAIL len1_pkt_count got %0d exp %0d", pkt_count, exp_seq); end
            if (k < 3) begin
                n = 0;
                while (tx_hdr_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
                vectors++; if (n != 1) begin miscompares++; $display("FAIL len1_spacing got %0d exp 1", n); end
            end
        end
    endtask

    task automatic test_incr();
        logic [31:0] s;
        do_reset();
        mode = 1'b1; payload_len = 11'd8; gap_cycles = 16'd0; enable = 1'b1;
        for (int k = 0; k < 2; k++) begin
            capture(0, -1);
            if (k == 1) enable = 1'b0;
            s = exp_seq; exp_seq++;
            vectors++; if (got_err != 0 || got.size() != 8 || got_last != 7) begin
                miscompares++; $display("FAIL incr_shape got err %0d n %0d last %0d exp 0 8 7", got_err, got.size(), got_last);
            end
            for (int i = 0; i < got.size(); i++) begin
                vectors++; if (got[i] !== model_byte(i, s, 1)) begin miscompares++; $display("FAIL incr_byte[%0d] got %02h exp %02h", i, got[i], model_byte(i, s, 1)); end
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] s;
        repeat (5) @(negedge clk);
        mode = 1'b1; payload_len = 11'd300; gap_cycles = 16'd0; enable = 1'b1;
        capture(0, -1);
        enable = 1'b0;
        s = exp_seq; exp_seq++;
        vectors++; if (got_err != 0 || got.size() != 300 || got_last != 299 || got_len !== 16'd308) begin
            miscompares++; $display("FAIL wrap_shape got err %0d n %0d last %0d len %0d exp 0 300 299 308", got_err, got.size(), got_last, got_len);
        end
        for (int i = 0; i < got.size(); i++) begin
            vectors++; if (got[i] !== model_byte(i, s, 1)) begin miscompares++; $display("FAIL wrap_byte[%0d] got %02h exp %02h", i, got[i], model_byte(i, s, 1)); end
        end
        if (got.size() > 260) begin
            vectors++; if (got[259] !== 8'hFF || got[260] !== 8'h00) begin miscompares++; $display("FAIL wrap_edge got %02h %02h exp ff 00", got[259], got[260]); end
        end
    endtask

    task automatic test_clamp();
        logic [31:0] s;
        int pls[2] = '{2000, 0};
        for (int k = 0; k < 2; k++) begin
            repeat (5) @(negedge clk);
            mode = 1'b0; payload_len = LEN_W'(pls[k]); gap_cycles = 16'd0; enable = 1'b1;
            capture(0, -1);
            enable = 1'b0;
            s = exp_seq; exp_seq++;
            vectors++; if (got_len !== 16'(model_len(pls[k]) + 8)) begin miscompares++; $display("FAIL clamp_length got %0d exp %0d", got_len, model_len(pls[k]) + 8); end
            vectors++; if (got_err != 0 || got.size() != model_len(pls[k]) || got_last != model_len(pls[k]) - 1) begin
                miscompares++; $display("FAIL clamp_shape got err %0d n %0d last %0d exp 0 %0d", got_err, got.size(), got_last, model_len(pls[k]));
            end
            for (int i = 0; i < got.size(); i++) begin
                vectors++; if (got[i] !== model_byte(i, s, 0)) begin miscompares++; $display("FAIL clamp_byte[%0d] got %02h exp %02h", i, got[i], model_byte(i, s, 0)); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int pl, g, n;
        bit m;
        logic [31:0] s;
        repeat (5) @(negedge clk);
        pl = $urandom_range(0, 40); m = 1'($urandom_range(0, 1)); g = $urandom_range(0, 5);
        payload_len = LEN_W'(pl); mode = m; gap_cycles = 16'(g); enable = 1'b1;
        for (int k = 0; k < 8; k++) begin
            capture(1, -1);
            s = exp_seq; exp_seq++;
            if (k == 7) enable = 1'b0;
            else begin
                payload_len = LEN_W'($urandom_range(0, 40));
                mode = 1'($urandom_range(0, 1));
                gap_cycles = 16'($urandom_range(0, 5));
            end
            vectors++; if (got_err != 0) begin miscompares++; $display("FAIL bp_proto got %0d exp 0", got_err); end
            vectors++; if (got_len !== 16'(model_len(pl) + 8)) begin miscompares++; $display("FAIL bp_length got %0d exp %0d", got_len, model_len(pl) + 8); end
            vectors++; if (got.size() != model_len(pl) || got_last != model_len(pl) - 1) begin
                miscompares++; $display("FAIL bp_count got %0d/%0d exp %0d", got.size(), got_last, model_len(pl));
            end
            for (int i = 0; i < got.size(); i++) begin
                vectors++; if (got[i] !== model_byte(i, s, m)) begin miscompares++; $display("FAIL bp_byte[%0d] got %02h exp %02h", i, got[i], model_byte(i, s, m)); end
            end
            vectors++; if (pkt_count !== exp_seq) begin miscompares++; $display("FAIL bp_pkt_count got %0d exp %0d", pkt_count, exp_seq); end
            if (k < 7) begin
                n = 0;
                while (tx_hdr_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
                vectors++; if (n != g + 1) begin miscompares++; $display("FAIL bp_gap got %0d exp %0d", n, g + 1); end
                pl = int'(payload_len); m = mode; g = int'(gap_cycles);
            end
        end
    endtask

    task automatic test_enable_drop();
        bit seen;
        logic [31:0] s;
        repeat (10) @(negedge clk);
        mode = 1'b1; payload_len = 11'd10; gap_cycles = 16'd0; enable = 1'b1;
        capture(0, 4);
        s = exp_seq; exp_seq++;
        vectors++; if (got_err != 0 || got.size() != 10 || got_last != 9) begin
            miscompares++; $display("FAIL drop_shape got err %0d n %0d last %0d exp 0 10 9", got_err, got.size(), got_last);
        end
        for (int i = 0; i < got.size(); i++) begin
            vectors++; if (got[i] !== model_byte(i, s, 1)) begin miscompares++; $display("FAIL drop_byte[%0d] got %02h exp %02h", i, got[i], model_byte(i, s, 1)); end
        end
        seen = 0;
        repeat (20) begin @(negedge clk); if (tx_hdr_valid === 1'b1) seen = 1; end
        vectors++; if (seen) begin miscompares++; $display("FAIL drop_no_hdr got 1 exp 0"); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL drop_busy got %0b exp 0", busy); end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [31:0] s;
        mode = 1'b0; payload_len = 11'd20; gap_cycles = 16'd0; enable = 1'b1;
        n = 0;
        while (tx_hdr_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        tx_hdr_ready = 1'b1;
        @(negedge clk);
        tx_hdr_ready = 1'b0;
        tx_tready = 1'b1;
        repeat (5) @(negedge clk);
        vectors++; if (tx_tvalid !== 1'b1) begin miscompares++; $display("FAIL rmid_pre_tvalid got %0b exp 1", tx_tvalid); end
        reset_n = 1'b0;
        @(negedge clk);
        vectors++; if (tx_tvalid !== 1'b0 || tx_tlast !== 1'b0) begin miscompares++; $display("FAIL rmid_tvalid got %0b%0b exp 00", tx_tvalid, tx_tlast); end
        vectors++; if (pkt_count !== 32'd0) begin miscompares++; $display("FAIL rmid_pkt_count got %0d exp 0", pkt_count); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy got %0b exp 0", busy); end
        tx_tready = 1'b0;
        reset_n = 1'b1;
        exp_seq = 0;
        capture(0, -1);
        enable = 1'b0;
        s = exp_seq; exp_seq++;
        vectors++; if (got_err != 0 || got.size() != 20) begin miscompares++; $display("FAIL rmid_shape got err %0d n %0d exp 0 20", got_err, got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            vectors++; if (got[i] !== model_byte(i, s, 0)) begin miscompares++; $display("FAIL rmid_byte[%0d] got %02h exp %02h", i, got[i], model_byte(i, s, 0)); end
        end
        vectors++; if (pkt_count !== 32'd1) begin miscompares++; $display("FAIL rmid_pkt_count_after got %0d exp 1", pkt_count); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        enable = 1'b0; mode = 1'b0; payload_len = '0; gap_cycles = '0;
        tx_hdr_ready = 1'b0; tx_tready = 1'b0;
        rx_hdr_valid = 1'b0; rx_tdata = '0; rx_tvalid = 1'b0; rx_tlast = 1'b0;
        test_reset();
        test_len1();
        test_incr();
        test_wrap();
        test_clamp();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/udp_pkt_gen.md
# udp_pkt_gen

Parametrised UDP traffic generator: emits UDP packets of runtime-selectable payload length, fill pattern and inter-packet gap onto the UDP stack's TX header and payload interfaces. Each payload starts with a 32-bit big-endian sequence number. It sits between the UDP stack and board-level control as a link-bring-up and throughput source, and sinks all RX traffic.

## Interface
Parameters:
- `PAYLOAD_LEN_MAX`, 1472: largest payload in bytes; sets `payload_len` width `LEN_W = $clog2(PAYLOAD_LEN_MAX+1)`.
- `SOURCE_IP`, 192.168.1.128: 32-bit IP source.
- `DEST_IP`, 192.168.1.2: 32-bit IP destination.
- `SOURCE_PORT`, 1234: 16-bit UDP source port.
- `DEST_PORT`, 5678: 16-bit UDP destination port.
- `TTL`, 64: 8-bit IP TTL.
- `FILL_BYTE`, 8'h45: byte used in constant mode.

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `udp_tx_header_if` UDP_TX_HEADER_IF.Source: TX header.
- `udp_tx_payload_if` AXIS_IF.Transmitter, 8-bit tdata: TX payload.
- `udp_rx_header_if` UDP_RX_HEADER_IF.Sink: RX header, always ready.
- `udp_rx_payload_if` AXIS_IF.Receiver: RX payload, always ready.
- `enable` in 1: run generator.
- `mode` in 1: 0 = constant `FILL_BYTE`, 1 = incrementing byte.
- `payload_len` in LEN_W: payload bytes per packet.
- `gap_cycles` in 16: idle cycles between packets.
- `pkt_count` out 32: completed packets (equals next sequence number).
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, HDR, PAYLOAD, GAP.
- IDLE: if `enable`, latch `mode`, effective length L and the current sequence number, then go to HDR.
- L = clamp(payload_len): 0 → 1, greater than `PAYLOAD_LEN_MAX` → `PAYLOAD_LEN_MAX`.
- HDR: `hdr_valid` = 1 until `hdr_valid && hdr_ready`, then go to PAYLOAD.
- Header fields:
  - `length` = L + 8, 16-bit.
  - `checksum` = 0, `ip_dscp` = 0, `ip_ecn` = 0.
  - Remaining fields come from the parameters.
- PAYLOAD: byte index i runs 0..L-1 and advances only on `tvalid && tready`.
  - Bytes 0..3 are seq[31:24], seq[23:16], seq[15:8], seq[7:0]. Only the first L of these are sent when L < 4.
  - Bytes at i ≥ 4 are `FILL_BYTE` in mode 0 and (i-4)[7:0] in mode 1; the mode-1 value wraps at 256.
  - `tlast` = 1 only on byte L-1. `tuser` = 0.
  - On the last-byte handshake: `pkt_count` += 1 (wraps at 2^32).
  - Next state on the last-byte handshake: GAP if `gap_cycles` ≠ 0, else IDLE.
- GAP: down-counter loaded with `gap_cycles` (value latched at packet end); go to IDLE when it reaches 1.
- `enable` falling mid-packet does not abort; the current packet completes and the next IDLE holds.
- `mode`, `payload_len` and `gap_cycles` changes take effect only at latch points.
- RX: `hdr_ready` = 1 and `tready` = 1 always; received data is discarded.

## Timing
- Reset values:
  - State is IDLE.
  - `hdr_valid`, `tvalid`, `tlast`, `busy` = 0.
  - `pkt_count` = 0; the sequence number is 0.
  - `tdata` = 0.
- Reset asserted mid-packet drops the packet immediately (no `tlast`); the downstream stack is reset alongside.
- All TX outputs are registered.
- `hdr_valid` rises 1 cycle after `enable` is sampled high in IDLE.
- First `tvalid` comes 1 cycle after the header handshake.
- Payload runs at 1 byte/cycle under continuous `tready`.
- Once asserted, `tvalid` and `tdata` stay stable until accepted (AXIS rules). Same for `hdr_valid` and the header fields.
- Gap between `tlast` acceptance and the next `hdr_valid`:
  - `gap_cycles` = 0: exactly 2 cycles (the acceptance cycle plus 1 IDLE cycle).
  - Otherwise: `gap_cycles` + 2 cycles.
- `pkt_count` updates the cycle after the `tlast` handshake.

## Structure
- Package `udp_pkt_gen_pkg` holds:
  - State enum `udp_pkt_gen_state_t`.
  - Mode enum `udp_pkt_gen_mode_t`.
  - Constants `UDP_HDR_BYTES = 8` and `SEQ_BYTES = 4`.
- One sub-module, `udp_pkt_gen_payload`: the combinational byte selector taking (index, seq, mode, fill) and returning `tdata`.
- FSM, counters and registers stay in the top module.

## Test plan
- `enable`=1, len=1, gap=0, `tready`=1: each packet has `length`=9 and a single byte 8'h00 with `tlast`=1. `pkt_count` is 1, 2, 3…; `hdr_valid` reasserts 2 cycles after each `tlast`.
- len=8, mode=1, second packet: bytes are 00 00 00 01 00 01 02 03, `tlast` on byte 7.
- len=300, mode=1: byte index 259 carries 8'hFF and byte 260 carries 8'h00 (wrap). len=2000 with the default MAX is clamped: `length`=1480, 1472 bytes sent.
- Random `tready` and `hdr_ready` backpressure: `tdata`/`tvalid` stable while stalled; the byte sequence is identical to the unstalled run.
- `enable` dropped at payload byte 3 of len=10: all 10 bytes are sent, then IDLE with `busy`=0 and no further `hdr_valid`.
- `reset_n` low mid-payload: next cycle `tvalid`=0, `pkt_count`=0; after release, the first packet carries seq 0.
